// File: rtl/ip1_test2_readback.sv
// rtl/ip1_test2_readback.sv - test2 scan-chain readback: sample, compare, pack into words
module ip1_test2_readback #(
   parameter int WORD_W = 32,
   parameter int CNT_W  = 14
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              enable,
   input  logic [6:0]        clk_counter_fc,
   input  logic [6:0]        sample_phase,
   input  logic              start_re,
   input  logic [CNT_W-1:0]  bit_cnt_max,
   input  logic              sm_testx_i_config_out,
   input  logic              sm_testx_i_expected_bit,
   output logic [WORD_W-1:0] word_data,
   output logic              word_valid,
   input  logic              word_ready,
   output logic [2:0]        rb_state,
   output logic [CNT_W-1:0]  rb_bit_cnt,
   output logic [CNT_W-1:0]  rb_err_cnt,
   output logic [CNT_W-1:0]  rb_first_err_idx,
   output logic              rb_overflow,
   output logic              rb_status_done
);

   // WORD_W is expected to be a power of two so the bit slot is the low counter bits
   localparam int IDX_W = $clog2(WORD_W);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_ARM     = 3'd1,
      S_CAPTURE = 3'd2,
      S_FLUSH   = 3'd3,
      S_DONE    = 3'd4
   } state_t;

   state_t             r_state;
   state_t             w_state_next;
   logic [WORD_W-1:0]  r_acc;
   logic [WORD_W-1:0]  r_word_data;
   logic               r_word_valid;
   logic [CNT_W-1:0]   r_bit_cnt;
   logic [CNT_W-1:0]   r_err_cnt;
   logic [CNT_W-1:0]   r_first_err_idx;
   logic               r_overflow;
   logic               r_status_done;

   logic               w_sample;
   logic [IDX_W-1:0]   w_idx;
   logic [CNT_W-1:0]   w_bit_cnt_inc;
   logic               w_mismatch;
   logic [WORD_W-1:0]  w_acc_next;
   logic               w_word_full;
   logic               w_partial;
   logic               w_can_load;
   logic               w_flush_push;
   logic               w_push;
   logic [WORD_W-1:0]  w_push_data;

   assign w_sample      = (clk_counter_fc == sample_phase);
   assign w_idx         = r_bit_cnt[IDX_W-1:0];
   assign w_bit_cnt_inc = r_bit_cnt + CNT_W'(1);
   assign w_mismatch    = sm_testx_i_config_out ^ sm_testx_i_expected_bit;
   assign w_word_full   = (r_state == S_CAPTURE) && w_sample && (w_idx == IDX_W'(WORD_W - 1));
   assign w_partial     = (w_idx != '0);
   // A new word may load when the output slot is empty or being emptied this cycle
   assign w_can_load    = !r_word_valid || word_ready;
   assign w_flush_push  = (r_state == S_FLUSH) && w_partial && w_can_load;
   assign w_push        = w_word_full || w_flush_push;
   assign w_push_data   = w_word_full ? w_acc_next : r_acc;

   // Accumulator with the current sample dropped into its slot
   always_comb begin
      w_acc_next        = r_acc;
      w_acc_next[w_idx] = sm_testx_i_config_out;
   end

   // State register
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   // Next-state logic; disabling the block parks it in IDLE
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         S_IDLE: begin
            if (start_re) begin
               w_state_next = (bit_cnt_max == '0) ? S_DONE : S_ARM;
            end
         end
         // One sample slot is skipped here to absorb the chain's output latency
         S_ARM: begin
            if (w_sample) begin
               w_state_next = S_CAPTURE;
            end
         end
         S_CAPTURE: begin
            if (w_sample && (w_bit_cnt_inc == bit_cnt_max)) begin
               w_state_next = S_FLUSH;
            end
         end
         S_FLUSH: begin
            if (!w_partial || w_can_load) begin
               w_state_next = S_DONE;
            end
         end
         S_DONE:  w_state_next = S_IDLE;
         default: w_state_next = S_IDLE;
      endcase
      if (!enable) begin
         w_state_next = S_IDLE;
      end
   end

   // Capture datapath: counters, error tracking, word packing and output handshake
   always_ff @(posedge clk) begin
      if (reset) begin
         r_acc           <= '0;
         r_word_data     <= '0;
         r_word_valid    <= 1'b0;
         r_bit_cnt       <= '0;
         r_err_cnt       <= '0;
         r_first_err_idx <= '1;
         r_overflow      <= 1'b0;
         r_status_done   <= 1'b0;
      end else if (enable) begin
         if (r_word_valid && word_ready) begin
            r_word_valid <= 1'b0;
         end
         if (w_push) begin
            if (w_can_load) begin
               r_word_data  <= w_push_data;
               r_word_valid <= 1'b1;
            end else begin
               r_overflow   <= 1'b1;
            end
         end
         case (r_state)
            S_IDLE: begin
               if (start_re) begin
                  r_acc           <= '0;
                  r_word_valid    <= 1'b0;
                  r_bit_cnt       <= '0;
                  r_err_cnt       <= '0;
                  r_first_err_idx <= '1;
                  r_overflow      <= 1'b0;
                  r_status_done   <= 1'b0;
               end
            end
            S_CAPTURE: begin
               if (w_sample) begin
                  r_acc     <= w_word_full ? '0 : w_acc_next;
                  r_bit_cnt <= w_bit_cnt_inc;
                  if (w_mismatch) begin
                     if (r_err_cnt != '1) begin
                        r_err_cnt <= r_err_cnt + CNT_W'(1);
                     end
                     if (r_err_cnt == '0) begin
                        r_first_err_idx <= r_bit_cnt;
                     end
                  end
               end
            end
            S_FLUSH: begin
               if (w_flush_push) begin
                  r_acc <= '0;
               end
            end
            S_DONE:  r_status_done <= 1'b1;
            default: ;
         endcase
      end
   end

   assign word_data        = r_word_data;
   assign word_valid       = r_word_valid;
   assign rb_state         = r_state;
   assign rb_bit_cnt       = r_bit_cnt;
   assign rb_err_cnt       = r_err_cnt;
   assign rb_first_err_idx = r_first_err_idx;
   assign rb_overflow      = r_overflow;
   assign rb_status_done   = r_status_done;

endmodule

// File: tb/tb_ip1_test2_readback.sv
// tb/tb_ip1_test2_readback.sv - scoreboard bench for ip1_test2_readback
module tb_ip1_test2_readback;

   localparam int WORD_W = 32;
   localparam int CNT_W  = 14;

   logic              clk = 1'b0;
   logic              reset;
   logic              enable;
   logic [6:0]        clk_counter_fc;
   logic [6:0]        sample_phase;
   logic              start_re;
   logic [CNT_W-1:0]  bit_cnt_max;
   logic              config_out;
   logic              expected_bit;
   logic [WORD_W-1:0] word_data;
   logic              word_valid;
   logic              word_ready;
   logic [2:0]        rb_state;
   logic [CNT_W-1:0]  rb_bit_cnt;
   logic [CNT_W-1:0]  rb_err_cnt;
   logic [CNT_W-1:0]  rb_first_err_idx;
   logic              rb_overflow;
   logic              rb_status_done;

   int                n_checks = 0;
   int                n_fail   = 0;
   int                phase_cnt = 0;
   logic [31:0]       exp_q[$];
   logic [95:0]       pat;

   ip1_test2_readback #(.WORD_W(WORD_W), .CNT_W(CNT_W)) dut (
      .clk                     (clk),
      .reset                   (reset),
      .enable                  (enable),
      .clk_counter_fc          (clk_counter_fc),
      .sample_phase            (sample_phase),
      .start_re                (start_re),
      .bit_cnt_max             (bit_cnt_max),
      .sm_testx_i_config_out   (config_out),
      .sm_testx_i_expected_bit (expected_bit),
      .word_data               (word_data),
      .word_valid              (word_valid),
      .word_ready              (word_ready),
      .rb_state                (rb_state),
      .rb_bit_cnt              (rb_bit_cnt),
      .rb_err_cnt              (rb_err_cnt),
      .rb_first_err_idx        (rb_first_err_idx),
      .rb_overflow             (rb_overflow),
      .rb_status_done          (rb_status_done)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Monitor: every accepted word is compared against the head of the scoreboard
   always @(negedge clk) begin
      if (!reset && word_valid && word_ready) begin
         if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL word_unexpected: got 0x%08h expected none", word_data);
         end else begin
            check("word_data", word_data, exp_q.pop_front());
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
      phase_cnt      = (phase_cnt == 15) ? 0 : phase_cnt + 1;
      clk_counter_fc = 7'(phase_cnt);
   endtask

   // Present one bit and advance until the DUT has seen a sample cycle with it
   task automatic sample_bit(input logic cfg, input logic exp, input logic rdy_at_sample);
      config_out   = cfg;
      expected_bit = exp;
      for (int k = 0; k < 20; k++) begin
         if (clk_counter_fc == sample_phase) begin
            if (rdy_at_sample) word_ready = 1'b1;
            tick();
            return;
         end
         tick();
      end
      n_checks++;
      n_fail++;
      $display("FAIL sample_timeout: got no sample cycle expected one within 20 cycles");
   endtask

   task automatic start_capture(input logic [CNT_W-1:0] max);
      bit_cnt_max = max;
      start_re    = 1'b1;
      tick();
      start_re    = 1'b0;
      sample_bit(1'b0, 1'b0, 1'b0);
   endtask

   task automatic check_reset_values(input string tag);
      check({tag, "_state"}, rb_state, 0);
      check({tag, "_valid"}, word_valid, 0);
      check({tag, "_data"}, word_data, 0);
      check({tag, "_bitcnt"}, rb_bit_cnt, 0);
      check({tag, "_errcnt"}, rb_err_cnt, 0);
      check({tag, "_firsterr"}, rb_first_err_idx, 14'h3FFF);
      check({tag, "_ovf"}, rb_overflow, 0);
      check({tag, "_done"}, rb_status_done, 0);
   endtask

   initial begin
      reset          = 1'b1;
      enable         = 1'b1;
      clk_counter_fc = '0;
      sample_phase   = 7'd10;
      start_re       = 1'b0;
      bit_cnt_max    = '0;
      config_out     = 1'b0;
      expected_bit   = 1'b0;
      word_ready     = 1'b1;
      tick();
      tick();
      reset = 1'b0;
      check_reset_values("rst");

      // 64 clean bits, consumer always ready
      pat = 96'h0_DEADBEEF_01234567;
      exp_q.push_back(32'h01234567);
      exp_q.push_back(32'hDEADBEEF);
      start_capture(14'd64);
      check("t1_capture", rb_state, 2);
      for (int i = 0; i < 64; i++) sample_bit(pat[i], pat[i], 1'b0);
      check("t1_flush", rb_state, 3);
      tick();
      check("t1_done_state", rb_state, 4);
      tick();
      check("t1_idle", rb_state, 0);
      check("t1_done", rb_status_done, 1);
      check("t1_errcnt", rb_err_cnt, 0);
      check("t1_firsterr", rb_first_err_idx, 14'h3FFF);
      check("t1_bitcnt", rb_bit_cnt, 64);
      check("t1_q_empty", exp_q.size(), 0);

      // 40 bits, mismatches at 5 and 33, partial final word; stray start_re mid-capture
      exp_q.push_back(32'h00000020);
      exp_q.push_back(32'h00000002);
      start_capture(14'd40);
      for (int i = 0; i < 40; i++) begin
         if (i == 20) begin
            start_re = 1'b1;
            tick();
            start_re = 1'b0;
            check("t2_restart_ignored_cnt", rb_bit_cnt, 20);
            check("t2_restart_ignored_state", rb_state, 2);
         end
         sample_bit((i == 5 || i == 33), 1'b0, 1'b0);
      end
      tick();
      tick();
      check("t2_errcnt", rb_err_cnt, 2);
      check("t2_firsterr", rb_first_err_idx, 5);
      check("t2_done", rb_status_done, 1);
      check("t2_q_empty", exp_q.size(), 0);

      // 96 bits with the consumer stalled: first word held, later words dropped
      word_ready = 1'b0;
      pat = 96'hCAFEF00D_89ABCDEF_13579BDF;
      start_capture(14'd96);
      for (int i = 0; i < 96; i++) begin
         sample_bit(pat[i], pat[i], 1'b0);
         if (i == 62) check("t3_ovf_before", rb_overflow, 0);
         if (i == 63) check("t3_ovf_at63", rb_overflow, 1);
      end
      check("t3_flush", rb_state, 3);
      tick();
      tick();
      check("t3_done", rb_status_done, 1);
      check("t3_ovf", rb_overflow, 1);
      check("t3_valid", word_valid, 1);
      check("t3_held_data", word_data, 32'h13579BDF);
      exp_q.push_back(32'h13579BDF);
      word_ready = 1'b1;
      tick();
      check("t3_drained", word_valid, 0);
      check("t3_q_empty", exp_q.size(), 0);

      // Second word completes in the same cycle the first is accepted
      word_ready = 1'b0;
      pat = 96'h0_0F0F0F0F_A5A5A5A5;
      exp_q.push_back(32'hA5A5A5A5);
      exp_q.push_back(32'h0F0F0F0F);
      start_capture(14'd64);
      for (int i = 0; i < 63; i++) sample_bit(pat[i], pat[i], 1'b0);
      check("t4_held", word_data, 32'hA5A5A5A5);
      sample_bit(pat[63], pat[63], 1'b1);
      check("t4_valid_stays", word_valid, 1);
      check("t4_new_data", word_data, 32'h0F0F0F0F);
      check("t4_no_ovf", rb_overflow, 0);
      tick();
      tick();
      check("t4_done", rb_status_done, 1);
      check("t4_q_empty", exp_q.size(), 0);

      // Reset in the middle of a capture, then a clean restart
      start_capture(14'd64);
      for (int i = 0; i < 17; i++) sample_bit((i == 3), 1'b0, 1'b0);
      check("t5_bitcnt17", rb_bit_cnt, 17);
      check("t5_err_before", rb_err_cnt, 1);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check_reset_values("t5_rst");
      pat = 96'h0_00000000_80000001;
      exp_q.push_back(32'h80000001);
      start_capture(14'd32);
      for (int i = 0; i < 32; i++) sample_bit(pat[i], pat[i], 1'b0);
      tick();
      tick();
      check("t5_restart_bitcnt", rb_bit_cnt, 32);
      check("t5_restart_err", rb_err_cnt, 0);
      check("t5_restart_done", rb_status_done, 1);
      check("t5_q_empty", exp_q.size(), 0);

      // Zero-length capture
      bit_cnt_max = '0;
      start_re    = 1'b1;
      tick();
      start_re    = 1'b0;
      check("t6_done_state", rb_state, 4);
      check("t6_done_cleared", rb_status_done, 0);
      tick();
      check("t6_idle", rb_state, 0);
      check("t6_done", rb_status_done, 1);
      check("t6_valid", word_valid, 0);

      // Dropping enable forces IDLE while registers hold
      bit_cnt_max = 14'd8;
      start_re    = 1'b1;
      tick();
      start_re    = 1'b0;
      check("t7_arm", rb_state, 1);
      enable = 1'b0;
      tick();
      check("t7_forced_idle", rb_state, 0);
      check("t7_bitcnt_hold", rb_bit_cnt, 0);
      enable = 1'b1;
      tick();
      check("t7_final_q_empty", exp_q.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
